// File: rtl/booth_control.sv
// rtl/booth_control.sv - radix-2 Booth multiplier sequencer (IDLE/LOAD/EVAL/SHIFT/FINISH)
// Optional macro BOOTH_DONE_HOLD_EN: FINISH holds done until start is sampled low.
module booth_control #(
   parameter int ITERATIONS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic Q0,
   input  logic Q1,
   output logic LoadA,
   output logic LoadB,
   output logic rs,
   output logic LoadAdd,
   output logic SEL,
   output logic Shift,
   output logic busy,
   output logic done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_EVAL   = 3'd2,
      S_SHIFT  = 3'd3,
      S_FINISH = 3'd4
   } state_e;

   localparam logic [3:0] LAST_CNT = 4'(ITERATIONS - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            cnt_d   = 4'd0;
            state_d = S_EVAL;
         end
         S_EVAL: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            cnt_d   = cnt_q + 4'd1;
            state_d = (cnt_q == LAST_CNT) ? S_FINISH : S_EVAL;
         end
         S_FINISH: begin
`ifdef BOOTH_DONE_HOLD_EN
            state_d = start ? S_FINISH : S_IDLE;
`else
            state_d = S_IDLE;
`endif
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Only LoadAdd/SEL look at the datapath bits; everything else is a pure state decode.
   always_comb begin
      LoadA   = 1'b0;
      LoadB   = 1'b0;
      rs      = 1'b0;
      LoadAdd = 1'b0;
      SEL     = 1'b0;
      Shift   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            LoadA = 1'b1;
            LoadB = 1'b1;
            rs    = 1'b1;
            busy  = 1'b1;
         end
         S_EVAL: begin
            busy    = 1'b1;
            LoadAdd = Q0 ^ Q1;
            SEL     = Q0 & ~Q1;
         end
         S_SHIFT: begin
            busy  = 1'b1;
            Shift = 1'b1;
         end
         S_FINISH: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_booth_control.sv
// tb/tb_booth_control.sv - bench for booth_control with a 4-bit Booth datapath model
module tb_booth_control;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic load_a, load_b, rs_o, load_add, sel, shift, busy, done;
   logic q0_w, q1_w;

   logic       closed = 1'b1;
   logic       tb_q0 = 1'b0, tb_q1 = 1'b0;
   logic [3:0] a_in = 4'd0, b_in = 4'd0;
   logic [3:0] dp_m, dp_acc, dp_q;
   logic       dp_q1;

   int passed = 0;
   int checks = 0;
   int fails  = 0;

   logic [7:0] sb[$];
   logic [1:0] dq[$];
   logic [1:0] qpat [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
   logic [1:0] dexp [4] = '{2'b11, 2'b10, 2'b00, 2'b00};

   always #5 clk = ~clk;

   booth_control #(.ITERATIONS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .Q0(q0_w), .Q1(q1_w),
      .LoadA(load_a), .LoadB(load_b), .rs(rs_o), .LoadAdd(load_add),
      .SEL(sel), .Shift(shift), .busy(busy), .done(done)
   );

   assign q0_w = closed ? dp_q[0] : tb_q0;
   assign q1_w = closed ? dp_q1   : tb_q1;

   // Reference Booth datapath: 4-bit accumulator, multiplier register and extra bit
   always @(posedge clk) begin
      if (load_a) dp_m <= a_in;
      if (load_b) dp_q <= b_in;
      if (rs_o) begin
         dp_acc <= 4'd0;
         dp_q1  <= 1'b0;
      end
      if (load_add) dp_acc <= sel ? dp_acc - dp_m : dp_acc + dp_m;
      if (shift) begin
         dp_acc <= {dp_acc[3], dp_acc[3:1]};
         dp_q   <= {dp_acc[0], dp_q[3:1]};
         dp_q1  <= dp_q[0];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed = passed + 1;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {load_a, load_b, rs_o, load_add, sel, shift, busy, done};
   endfunction

   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int hold,
                         input int exp_done, input string tag);
      int ai, bi, p, nadd_exp;
      int n_shift, n_add, n_loada, n_done, done_cyc, overlap;
      logic prev;
      logic [7:0] exp_p;
      ai = $signed(a);
      bi = $signed(b);
      p = ai * bi;
      exp_p = p[7:0];
      sb.push_back(exp_p);
      nadd_exp = 0;
      prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (b[i] != prev) nadd_exp++;
         prev = b[i];
      end
      n_shift = 0; n_add = 0; n_loada = 0; n_done = 0; done_cyc = 0; overlap = 0;
      closed = 1'b1;
      @(negedge clk);
      a_in = a;
      b_in = b;
      start = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clk);
         n_shift += int'(shift);
         n_add   += int'(load_add);
         n_loada += int'(load_a);
         n_done  += int'(done);
         if (load_add && shift) overlap++;
         if (done && done_cyc == 0) begin
            done_cyc = cyc;
            check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check({tag, "_product"}, {24'd0, dp_acc, dp_q}, {24'd0, sb.pop_front()});
         end
         if (cyc >= hold) start = 1'b0;
      end
      check({tag, "_shifts"}, n_shift, 4);
      check({tag, "_loadadds"}, n_add, nadd_exp);
      check({tag, "_loada"}, n_loada, 1);
      check({tag, "_done_cycle"}, done_cyc, 10);
      check({tag, "_done_len"}, n_done, exp_done);
      check({tag, "_overlap"}, overlap, 0);
   endtask

   initial begin
      int k;
      rst = 1'b0;
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reset_outs", {24'd0, outs()}, 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      check("first_edge_load", {29'd0, load_a, load_b, rs_o}, 32'd7);
      start = 1'b0;
      repeat (14) @(negedge clk);
      check("idle_after_first", {24'd0, outs()}, 32'd0);

      run_op(4'b0101, 4'b0000, 0, 1, "zero_b");
      run_op(4'b1101, 4'b0101, 0, 1, "m3x5");
      run_op(4'b0011, 4'b0010, 0, 1, "3x2");
      run_op(4'b0111, 4'b1010, 0, 1, "7xm6");

      closed = 1'b0;
      k = 0;
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy && !load_a && !shift && k < 4) begin
            {tb_q0, tb_q1} = qpat[k];
            dq.push_back(dexp[k]);
            k++;
            #1;
            check("decode", {30'd0, load_add, sel}, {30'd0, dq.pop_front()});
         end
      end
      check("decode_evals", k, 4);
      {tb_q0, tb_q1} = 2'b00;
      closed = 1'b1;

      a_in = 4'b1101;
      b_in = 4'b0101;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("third_shift", {31'd0, shift}, 32'd1);
      rst = 1'b0;
      #1;
      check("async_reset_outs", {24'd0, outs()}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post_reset_idle", {24'd0, outs()}, 32'd0);
      end
      run_op(4'b0011, 4'b0010, 0, 1, "restart_3x2");

`ifdef BOOTH_DONE_HOLD_EN
      run_op(4'b1101, 4'b0101, 12, 3, "done_hold");
`else
      run_op(4'b1101, 4'b0101, 10, 1, "done_pulse");
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/booth_control.md
BOOTH_CONTROL -- requirements
Module: booth_control

Interface
REQ-001 Parameter ITERATIONS, default 4, meaning the number of add/shift iterations (operand width); legal range 2..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new multiplication; sampled only in IDLE.
REQ-005 Q0  input  1  multiplier LSB from the datapath.
REQ-006 Q1  input  1  Booth extra bit from the datapath.
REQ-007 LoadA  output  1  load multiplicand register.
REQ-008 LoadB  output  1  load multiplier register.
REQ-009 rs  output  1  synchronous clear of accumulator and Q1 bit.
REQ-010 LoadAdd  output  1  load adder/subtractor result into accumulator.
REQ-011 SEL  output  1  0 = add, 1 = subtract.
REQ-012 Shift  output  1  arithmetic right shift of {accumulator, multiplier, Q1}.
REQ-013 busy  output  1  high from LOAD through the last SHIFT.
REQ-014 done  output  1  product valid on the datapath.

Function
REQ-015 States SHALL be IDLE, LOAD, EVAL, SHIFT and FINISH.
REQ-016 IDLE: all control outputs SHALL be 0; start=1 at a rising edge SHALL move the FSM to LOAD.
REQ-017 LOAD: LoadA, LoadB and rs SHALL be 1 for exactly one cycle; the iteration counter SHALL clear to 0; next state EVAL.
REQ-018 EVAL: {Q0,Q1}=10 SHALL give LoadAdd=1, SEL=1; 01 SHALL give LoadAdd=1, SEL=0; 00 or 11 SHALL give LoadAdd=0, SEL=0; next state SHIFT.
REQ-019 LoadAdd and SEL SHALL be combinational (Mealy) in EVAL only; all other outputs SHALL decode from state alone.
REQ-020 SHIFT: Shift SHALL be 1 for one cycle and the counter SHALL increment; if the counter equals ITERATIONS-1, next state SHALL be FINISH, otherwise EVAL.
REQ-021 Counter SHALL be 4 bits and SHALL never wrap within a legal operation.
REQ-022 Latency: with start sampled at edge E0, done SHALL first be high in the cycle after edge E0+2*ITERATIONS+1 (cycle 10 for ITERATIONS=4).
REQ-023 Exactly ITERATIONS Shift pulses and at most ITERATIONS LoadAdd pulses SHALL occur per operation.
REQ-024 start while busy or in FINISH SHALL be ignored; no operation SHALL be queued.
REQ-025 LoadAdd and Shift SHALL never be high in the same cycle.

Reset
REQ-026 rst=0 SHALL force the IDLE state, counter=0 and every output to 0 immediately, without waiting for clk.
REQ-027 Reset asserted mid-operation SHALL abandon the operation; after release, the FSM SHALL wait in IDLE for a new start.
REQ-028 The first rising edge after rst deasserts SHALL act as a normal IDLE edge.

Configuration
REQ-029 Macro BOOTH_DONE_HOLD_EN defined: FINISH SHALL hold done=1 until start is sampled 0, then go to IDLE.
REQ-030 Macro BOOTH_DONE_HOLD_EN undefined: done SHALL be a single-cycle pulse, and FINISH SHALL always go to IDLE on the next edge.

Verification
REQ-031 Reset: rst=0 with start=1 and clk toggling -> all outputs 0 and no LoadA pulse; release -> LoadA in the cycle after the first start sample.
REQ-032 Latency: start pulse, Q0/Q1 held 00 -> 1 LOAD cycle, 4 Shift pulses, 0 LoadAdd pulses, done in cycle 10.
REQ-033 Decode: bench drives {Q0,Q1}=10, 01, 11, 00 in successive EVAL cycles -> (LoadAdd,SEL) = (1,1), (1,0), (0,0), (0,0).
REQ-034 Closed loop with the 4-bit Booth datapath, A=4'b1101 (-3), B=4'b0101 (5) -> prod=8'hF1 at done; A=3, B=2 -> prod=8'h06.
REQ-035 Mid-operation: assert rst in the third SHIFT, re-start after release -> full 10-cycle sequence with correct product.
REQ-036 Done mode: start held high through FINISH -> done held until start falls with the macro; single-cycle done pulse without it and no re-trigger until IDLE.
